// File: rtl/idct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idct_pkg
//  Description : Shared constants, FSM state type and packed-vector helpers
//                for the 8x8 IDCT tile scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package idct_pkg;

   localparam int ML = 16;   // word width of coefficients / results
   localparam int N  = 8;    // tile edge

   // Fixed-point cosine constants used by the companion 1-D IDCT unit
   localparam int W1 = 2841;
   localparam int W2 = 2676;
   localparam int W3 = 2408;
   localparam int W4 = 2048;
   localparam int W5 = 1609;
   localparam int W6 = 1108;
   localparam int W7 = 565;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ROW   = 2'd1,
      ST_COL   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Extract element k from an N*ML packed operand vector
   function automatic logic [ML-1:0] vec_get(input logic [N*ML-1:0] v,
                                             input logic [2:0]      k);
      return v[int'(k)*ML +: ML];
   endfunction

   // Return v with element k replaced by w
   function automatic logic [N*ML-1:0] vec_set(input logic [N*ML-1:0] v,
                                               input logic [2:0]      k,
                                               input logic [ML-1:0]   w);
      logic [N*ML-1:0] r;
      r = v;
      r[int'(k)*ML +: ML] = w;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idct_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : idct_tile_buf
//  Description : 8x8 word tile store with raster, row and column access.
//                Reads are combinational; at most one write port is used
//                per cycle (the scheduler guarantees exclusivity).
//  Revision    : 1.0  initial release
// ============================================================================
module idct_tile_buf
   import idct_pkg::*;
(
   input  logic              clk,
   input  logic              rast_we_i,
   input  logic [5:0]        rast_idx_i,
   input  logic [ML-1:0]     rast_wdata_i,
   output logic [ML-1:0]     rast_rdata_o,
   input  logic              row_we_i,
   input  logic [2:0]        row_idx_i,
   input  logic [N*ML-1:0]   row_wdata_i,
   output logic [N*ML-1:0]   row_rdata_o,
   input  logic              col_we_i,
   input  logic [2:0]        col_idx_i,
   input  logic [N*ML-1:0]   col_wdata_i,
   output logic [N*ML-1:0]   col_rdata_o
);

   logic [ML-1:0] mem_q [N][N];

   // Tile storage update; contents need no reset since every tile is fully rewritten
   always_ff @(posedge clk) begin
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (rast_we_i && rast_idx_i == 6'(r*N + c)) begin
               mem_q[r][c] <= rast_wdata_i;
            end else if (row_we_i && row_idx_i == 3'(r)) begin
               mem_q[r][c] <= vec_get(row_wdata_i, 3'(c));
            end else if (col_we_i && col_idx_i == 3'(c)) begin
               mem_q[r][c] <= vec_get(col_wdata_i, 3'(r));
            end
         end
      end
   end

   assign rast_rdata_o = mem_q[rast_idx_i[5:3]][rast_idx_i[2:0]];

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_port
         assign row_rdata_o[g*ML +: ML] = mem_q[row_idx_i][g];
         assign col_rdata_o[g*ML +: ML] = mem_q[g][col_idx_i];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/idct_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : idct_tile_sched
//  Description : Loads an 8x8 coefficient tile, drives an external 1-D IDCT
//                unit over 8 rows then 8 columns, and streams the result out
//                in raster order. Single buffer: no load/drain overlap.
//  Revision    : 1.0  initial release
// ============================================================================
module idct_tile_sched
   import idct_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ML-1:0]     in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ML-1:0]     out_data,
   output logic              out_last,
   output logic              dp_mode,
   output logic [N*ML-1:0]   dp_in,
   input  logic [N*ML-1:0]   dp_out,
   output logic              busy
);

   state_e          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            rast_we, row_we, col_we;
   logic [N*ML-1:0] row_rdata, col_rdata;

   idct_tile_buf u_buf (
      .clk          (clk),
      .rast_we_i    (rast_we),
      .rast_idx_i   (cnt_q),
      .rast_wdata_i (in_data),
      .rast_rdata_o (out_data),
      .row_we_i     (row_we),
      .row_idx_i    (cnt_q[2:0]),
      .row_wdata_i  (dp_out),
      .row_rdata_o  (row_rdata),
      .col_we_i     (col_we),
      .col_idx_i    (cnt_q[2:0]),
      .col_wdata_i  (dp_out),
      .col_rdata_o  (col_rdata)
   );

   // State and beat/pass counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, buffer port selection and handshake outputs; abort overrides all
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      dp_mode   = 1'b0;
      dp_in     = '0;
      rast_we   = 1'b0;
      row_we    = 1'b0;
      col_we    = 1'b0;
      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && !abort) begin
               rast_we = 1'b1;
               if (cnt_q == 6'd63) begin
                  state_d = ST_ROW;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         ST_ROW: begin
            dp_in  = row_rdata;
            row_we = !abort;
            if (cnt_q[2:0] == 3'd7) begin
               state_d = ST_COL;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_COL: begin
            dp_mode = 1'b1;
            dp_in   = col_rdata;
            col_we  = !abort;
            if (cnt_q[2:0] == 3'd7) begin
               state_d = ST_DRAIN;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            out_last  = (cnt_q == 6'd63);
            if (out_ready) begin
               if (cnt_q == 6'd63) begin
                  state_d = ST_LOAD;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            cnt_d   = 6'd0;
         end
      endcase
      if (abort) begin
         state_d = ST_LOAD;
         cnt_d   = 6'd0;
      end
   end

   assign busy = !(state_q == ST_LOAD && cnt_q == 6'd0);

endmodule
`default_nettype wire
